// File: rtl/range_seq_framer.sv
// Frames a header-prefixed byte stream into go/sample/finish timing for the range finder.
// Optional build macro FRAMER_TIMEOUT_EN adds a stall timeout in RUN that forces a truncated finish.
module range_seq_framer #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] data_out,
  output logic             go,
  output logic             finish,
  output logic             busy,
  output logic             zero_len,
  output logic             trunc
);

  typedef enum logic [1:0] {
    S_HDR,
    S_FIRST,
    S_RUN,
    S_HOLD1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] remaining_q, remaining_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             go_q, go_d;
  logic             finish_q, finish_d;
  logic             zero_len_q, zero_len_d;
  logic             xfer;

`ifdef FRAMER_TIMEOUT_EN
  localparam int unsigned IdleW = $clog2(TIMEOUT + 1);

  logic [IdleW-1:0] idle_q, idle_d;
  logic [IdleW-1:0] idle_inc;
  logic             trunc_q, trunc_d;

  assign idle_inc = idle_q + IdleW'(1);
`endif

  // HOLD1 is the only state that refuses data; that refusal is what separates go from finish.
  assign in_ready = rst_n & (state_q != S_HOLD1);
  assign xfer     = in_valid & in_ready;
  assign busy     = (state_q != S_HDR);

  // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    data_d      = data_q;
    go_d        = 1'b0;
    finish_d    = 1'b0;
    zero_len_d  = 1'b0;
`ifdef FRAMER_TIMEOUT_EN
    idle_d      = '0;
    trunc_d     = 1'b0;
`endif

    unique case (state_q)
      S_HDR: begin
        if (xfer) begin
          if (in_data == '0) begin
            zero_len_d = 1'b1;
          end else begin
            remaining_d = in_data;
            state_d     = S_FIRST;
          end
        end
      end

      S_FIRST: begin
        if (xfer) begin
          data_d      = in_data;
          go_d        = 1'b1;
          remaining_d = remaining_q - WIDTH'(1);
          state_d     = (remaining_q == WIDTH'(1)) ? S_HOLD1 : S_RUN;
        end
      end

      S_RUN: begin
        if (xfer) begin
          data_d      = in_data;
          remaining_d = remaining_q - WIDTH'(1);
          if (remaining_q == WIDTH'(1)) begin
            finish_d = 1'b1;
            state_d  = S_HDR;
          end
`ifdef FRAMER_TIMEOUT_EN
        end else if (idle_inc == IdleW'(TIMEOUT)) begin
          // Abandon the sequence; the last sample stays on data_out alongside finish.
          finish_d    = 1'b1;
          trunc_d     = 1'b1;
          remaining_d = '0;
          state_d     = S_HDR;
        end else begin
          idle_d = idle_inc;
`endif
        end
      end

      S_HOLD1: begin
        finish_d = 1'b1;
        state_d  = S_HDR;
      end

      default: state_d = S_HDR;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  // NOTE: every register here is reset; there is no storage array that could be left unreset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_HDR;
      remaining_q <= '0;
      data_q      <= '0;
      go_q        <= 1'b0;
      finish_q    <= 1'b0;
      zero_len_q  <= 1'b0;
`ifdef FRAMER_TIMEOUT_EN
      idle_q      <= '0;
      trunc_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      data_q      <= data_d;
      go_q        <= go_d;
      finish_q    <= finish_d;
      zero_len_q  <= zero_len_d;
`ifdef FRAMER_TIMEOUT_EN
      idle_q      <= idle_d;
      trunc_q     <= trunc_d;
`endif
    end
  end

  assign data_out = data_q;
  assign go       = go_q;
  assign finish   = finish_q;
  assign zero_len = zero_len_q;
`ifdef FRAMER_TIMEOUT_EN
  assign trunc    = trunc_q;
`else
  assign trunc    = 1'b0;
`endif

endmodule

// File: tb/tb_range_seq_framer.sv
// Directed bench for range_seq_framer; outputs are sampled 1ns after each rising edge.
module tb_range_seq_framer;

  localparam int unsigned WIDTH   = 8;
  localparam int unsigned TIMEOUT = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] data_out;
  logic             go;
  logic             finish;
  logic             busy;
  logic             zero_len;
  logic             trunc;

  int checks = 0;
  int errors = 0;

  range_seq_framer #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .data_out (data_out),
    .go       (go),
    .finish   (finish),
    .busy     (busy),
    .zero_len (zero_len),
    .trunc    (trunc)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present one word for one clock edge, then settle past the edge.
  task automatic step(input logic v, input logic [WIDTH-1:0] d);
    in_valid = v;
    in_data  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic check_strobes(input string tag, input logic g, input logic f, input logic b);
    check({tag, "_go"}, go, g);
    check({tag, "_finish"}, finish, f);
    check({tag, "_busy"}, busy, b);
  endtask

  initial begin
    int fin_seen;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    #12;
    check("rst_data", data_out, 0);
    check("rst_ready", in_ready, 0);
    check("rst_zero_len", zero_len, 0);
    check("rst_trunc", trunc, 0);
    check_strobes("rst", 0, 0, 0);
    rst_n = 1'b1;
    #1;
    check("rst_rel_ready", in_ready, 1);
    @(posedge clk);
    #1;

    // 1: length 3, back-to-back samples
    step(1, 3);  check_strobes("t1_hdr", 0, 0, 1);
    step(1, 10); check_strobes("t1_s0", 1, 0, 1); check("t1_d0", data_out, 10);
    check("t1_ready", in_ready, 1);
    step(1, 50); check_strobes("t1_s1", 0, 0, 1); check("t1_d1", data_out, 50);
    step(1, 20); check_strobes("t1_s2", 0, 1, 0); check("t1_d2", data_out, 20);
    step(0, 0);  check_strobes("t1_idle", 0, 0, 0);

    // 2: length 1; a word offered during HOLD1 must be refused
    step(1, 1);
    step(1, 7);  check_strobes("t2_s0", 1, 0, 1); check("t2_d0", data_out, 7);
    check("t2_ready_hold", in_ready, 0);
    step(1, 8'hAA); check_strobes("t2_fin", 0, 1, 0); check("t2_dfin", data_out, 7);
    check("t2_ready_after", in_ready, 1);
    step(0, 0);  check_strobes("t2_idle", 0, 0, 0);

    // 3: zero-length header, then length 2
    step(1, 0);  check("t3_zl", zero_len, 1); check_strobes("t3_zl", 0, 0, 0);
    step(1, 2);  check("t3_zl_off", zero_len, 0); check_strobes("t3_hdr", 0, 0, 1);
    step(1, 4);  check_strobes("t3_s0", 1, 0, 1); check("t3_d0", data_out, 4);
    step(1, 9);  check_strobes("t3_s1", 0, 1, 0); check("t3_d1", data_out, 9);

    // 4: header accepted in the finish cycle, gap of 3 idle cycles mid-sequence
    step(1, 4);  check_strobes("t4_hdr", 0, 0, 1);
    step(1, 1);  check_strobes("t4_s0", 1, 0, 1); check("t4_d0", data_out, 1);
    step(1, 2);  check("t4_d1", data_out, 2);
    for (int i = 0; i < 3; i++) begin
      step(0, 8'h55);
      check_strobes($sformatf("t4_gap%0d", i), 0, 0, 1);
      check($sformatf("t4_gapd%0d", i), data_out, 2);
    end
    step(1, 3);  check("t4_d2", data_out, 3); check_strobes("t4_s2", 0, 0, 1);
    step(1, 4);  check_strobes("t4_s3", 0, 1, 0); check("t4_d3", data_out, 4);

    // 5: asynchronous reset mid-sequence, then a fresh sequence
    step(1, 5);
    step(1, 11); check("t5_go_pre", go, 1);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_data", data_out, 0);
    check("t5_rst_ready", in_ready, 0);
    check_strobes("t5_rst", 0, 0, 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(1, 3);  check_strobes("t5_hdr", 0, 0, 1);
    step(1, 1);  check_strobes("t5_s0", 1, 0, 1); check("t5_d0", data_out, 1);
    step(1, 2);  check("t5_d1", data_out, 2);
    step(1, 3);  check_strobes("t5_s2", 0, 1, 0); check("t5_d2", data_out, 3);

    // 6: stall in RUN
    step(1, 5);
    step(1, 8);  check("t6_d0", data_out, 8);
    step(1, 6);  check("t6_d1", data_out, 6);
`ifdef FRAMER_TIMEOUT_EN
    for (int i = 0; i < 3; i++) begin
      step(0, 0);
      check_strobes($sformatf("t6_wait%0d", i), 0, 0, 1);
      check($sformatf("t6_trunc_wait%0d", i), trunc, 0);
    end
    step(0, 0);
    check_strobes("t6_to", 0, 1, 0);
    check("t6_trunc", trunc, 1);
    check("t6_to_data", data_out, 6);
    step(0, 0);  check("t6_trunc_off", trunc, 0); check_strobes("t6_after", 0, 0, 0);
    step(1, 1);  check_strobes("t6_hdr", 0, 0, 1);
    step(1, 2);  check_strobes("t6_s0", 1, 0, 1);
    step(0, 0);  check_strobes("t6_hold", 0, 1, 0);
`else
    for (int i = 0; i < 6; i++) begin
      step(0, 0);
      check_strobes($sformatf("t6_wait%0d", i), 0, 0, 1);
      check($sformatf("t6_trunc_wait%0d", i), trunc, 0);
      check($sformatf("t6_hold%0d", i), data_out, 6);
    end
    step(1, 3);
    step(1, 4);  check_strobes("t6_s3", 0, 0, 1);
    step(1, 7);  check_strobes("t6_s4", 0, 1, 0); check("t6_d4", data_out, 7);
    check("t6_trunc", trunc, 0);
`endif
    step(0, 0);

    // 7: maximum length 255
    fin_seen = 0;
    step(1, 8'hFF);
    for (int i = 0; i < 255; i++) begin
      step(1, WIDTH'(i + 1));
      if (i == 0) check("t7_go", go, 1);
      if (i < 254 && finish) fin_seen++;
    end
    check("t7_early_finish", fin_seen, 0);
    check_strobes("t7_last", 0, 1, 0);
    check("t7_dlast", data_out, 255);
    step(0, 0);  check_strobes("t7_idle", 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
